// File: rtl/jt08_adpcm_pkg.sv
// Shared constants for the ADPCM-B sample RAM arbiter family.
package jt08_adpcm_pkg;
  localparam int DEF_AW = 24;
  localparam int DEF_DW = 8;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
endpackage

// File: rtl/jt08_arb_age.sv
// Saturating wait-age counter for the low-priority requester plus its force flag.
module jt08_arb_age
  import jt08_adpcm_pkg::*;
#(
  parameter int MAXWAIT = 6
)(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic force_b
);
  logic [3:0] bwait;

  // Once forced, the count freezes so the forced window cannot extend itself.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bwait <= '0;
    end else if (inc && !force_b && bwait != 4'hF) begin
      bwait <= bwait + 4'd1;
    end
  end

  assign force_b = (bwait >= 4'(MAXWAIT));
endmodule

// File: rtl/jt08_adpcm_ram_arb.sv
// Two-requester arbiter for the external ADPCM-B sample RAM: A has priority, B is aged.
module jt08_adpcm_ram_arb
  import jt08_adpcm_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MAXWAIT = 6,
  parameter int TOUT    = 63
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          owner,
  output logic          tout_err
);
  logic [1:0]    state;
  logic [7:0]    timer;
  logic          grant;
  logic          win_b;
  logic          force_b;
  logic          age_inc;
  logic [DW-1:0] rd_val;

  assign grant   = (state == ARB_IDLE) && (a_req || b_req);
  assign win_b   = (force_b && b_req) || !a_req;
  assign age_inc = (state == ARB_BUSY) && (owner == OWN_A) && b_req;
  // An aborted read returns all ones so the driver sees an obviously bad sample.
  assign rd_val  = m_ack ? m_rdata : {DW{1'b1}};

  jt08_arb_age #(
    .MAXWAIT(MAXWAIT)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .inc     (age_inc),
    .clr     (grant && win_b),
    .force_b (force_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      timer    <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      owner    <= OWN_A;
      tout_err <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant) begin
            owner   <= win_b ? OWN_B : OWN_A;
            m_req   <= 1'b1;
            m_we    <= win_b ? b_we : a_we;
            m_addr  <= win_b ? b_addr : a_addr;
            m_wdata <= win_b ? b_wdata : a_wdata;
            timer   <= '0;
            state   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A late m_ack coinciding with the timeout still wins.
          if (m_ack || timer == 8'(TOUT - 1)) begin
            m_req <= 1'b0;
            m_we  <= 1'b0;
            state <= ARB_DONE;
            if (!m_ack) tout_err <= 1'b1;
            if (owner == OWN_B) begin
              b_ack <= 1'b1;
              if (!m_we) b_rdata <= rd_val;
            end else begin
              a_ack <= 1'b1;
              if (!m_we) a_rdata <= rd_val;
            end
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jt08_adpcm_ram_arb.sv
// Scoreboard bench for jt08_adpcm_ram_arb: random requesters, behavioural arbitration model.
module tb_jt08_adpcm_ram_arb;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int MAXWAIT = 6;
  localparam int TOUT = 63;
  localparam int ACK_BOUND = 300;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, m_addr;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic a_ack, b_ack, m_req, m_we, owner, tout_err;
  logic m_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;
  bit mem_dead = 1'b0;
  int lat_left = 0;
  logic [DW-1:0] last_rd [2];
  txn_t exp_a [$];
  txn_t exp_b [$];

  always #5 clk = ~clk;

  jt08_adpcm_ram_arb #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .owner(owner), .tout_err(tout_err)
  );

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester: queue the expected completion, hold req until its ack.
  task automatic do_req(input bit who, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    txn_t t;
    int n;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    if (we) t.rdata = last_rd[who];
    else    t.rdata = mem_dead ? 8'hFF : mem_f(addr);
    last_rd[who] = t.rdata;
    if (who) begin
      exp_b.push_back(t);
      b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end else begin
      exp_a.push_back(t);
      a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    end
    $display("issue %s we=%0d addr=%06h wdata=%02h exp_rdata=%02h", who ? "B" : "A", we, addr, wdata, t.rdata);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(who ? b_ack : a_ack) && n < ACK_BOUND);
    chk(who ? "b_ack_wait" : "a_ack_wait", 32'(n >= ACK_BOUND), 32'd0);
    if (who) b_req = 1'b0;
    else     a_req = 1'b0;
  endtask

  task automatic rand_stream(input bit who, input int count, input int max_gap);
    for (int i = 0; i < count; i++) begin
      do_req(who, 1'($urandom_range(0, 1)), 24'($urandom), 8'($urandom));
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  // Memory: random latency, stray m_ack pulses while idle, or silent when dead.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      m_rdata = 8'($urandom);
      if (m_req && !mem_dead) begin
        if (lat_left == 0) begin
          m_ack = 1'b1;
          m_rdata = mem_f(m_addr);
          lat_left = $urandom_range(0, 3);
        end else begin
          lat_left--;
        end
      end else if (!m_req && $urandom_range(0, 7) == 0) begin
        m_ack = 1'b1;
      end
    end
  end

  // Monitor: arbitration rule, command stability, ack timing and read data.
  initial begin
    bit prev_mreq, acked, cur_own, pa, pb, exp_own, nxt_valid, nxt_mreq;
    int bw, busy;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    txn_t t;
    prev_mreq = 0; acked = 0; cur_own = 0; pa = 0; pb = 0; bw = 0; busy = 0;
    nxt_valid = 0; nxt_mreq = 0; g_we = 0; g_addr = '0; g_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev_mreq = 0; acked = 0; bw = 0; busy = 0; nxt_valid = 0;
        pa = a_req; pb = b_req;
        continue;
      end
      if (nxt_valid) chk("req_to_mreq", 32'(m_req), 32'(nxt_mreq));
      nxt_valid = 0;
      if (a_ack || b_ack) chk("ack_exclusive", 32'(a_ack && b_ack), 32'd0);
      if (!prev_mreq && m_req) begin
        // B is forced after waiting MAXWAIT cycles behind A, else A has priority.
        exp_own = (bw >= MAXWAIT) ? 1'b1 : (pa ? 1'b0 : 1'b1);
        chk("grant_owner", 32'(owner), 32'(exp_own));
        cur_own = exp_own;
        if (exp_own) bw = 0;
        chk("grant_queue_nonempty", 32'(cur_own ? exp_b.size() : exp_a.size()), 32'((cur_own ? exp_b.size() : exp_a.size()) == 0 ? 1 : (cur_own ? exp_b.size() : exp_a.size())));
        if ((cur_own ? exp_b.size() : exp_a.size()) > 0) begin
          t = cur_own ? exp_b[0] : exp_a[0];
          chk("grant_addr", 32'(m_addr), 32'(t.addr));
          chk("grant_we", 32'(m_we), 32'(t.we));
          if (t.we) chk("grant_wdata", 32'(m_wdata), 32'(t.wdata));
        end else begin
          chk("grant_without_request", 32'd1, 32'd0);
        end
        g_we = m_we; g_addr = m_addr; g_wdata = m_wdata;
        acked = 0; busy = 0;
      end
      if (m_req) begin
        busy++;
        chk("ack_latency", 32'(acked), 32'd0);
        chk("cmd_stable", 32'({m_we, m_addr, m_wdata}), 32'({g_we, g_addr, g_wdata}));
        chk("no_ack_while_busy", 32'(a_ack || b_ack), 32'd0);
        if (m_ack) acked = 1;
        if (!cur_own && b_req && bw < MAXWAIT) bw++;
      end else if (prev_mreq) begin
        chk(cur_own ? "b_ack_pulse" : "a_ack_pulse", 32'({a_ack, b_ack}), cur_own ? 32'd1 : 32'd2);
        if (cur_own) t = exp_b.pop_front();
        else         t = exp_a.pop_front();
        chk(cur_own ? "b_rdata" : "a_rdata", 32'(cur_own ? b_rdata : a_rdata), 32'(t.rdata));
        if (!acked) begin
          chk("timeout_busy_cycles", 32'(busy), 32'(TOUT));
          chk("tout_err_set", 32'(tout_err), 32'd1);
        end
        $display("done %s we=%0d addr=%06h rdata=%02h %s", cur_own ? "B" : "A", t.we, t.addr,
                 cur_own ? b_rdata : a_rdata, acked ? "ok" : "timeout");
        nxt_valid = 1; nxt_mreq = 0;
      end else begin
        chk("no_stray_ack", 32'(a_ack || b_ack), 32'd0);
        nxt_valid = 1; nxt_mreq = a_req || b_req;
      end
      prev_mreq = m_req; pa = a_req; pb = b_req;
    end
  end

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_port", 32'({m_req, m_we, m_addr}), 32'd0);
    chk("rst_wdata_owner", 32'({m_wdata, owner, tout_err}), 32'd0);
    chk("rst_rdata_ack", 32'({a_rdata, b_rdata, a_ack, b_ack}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    lat_left = 2;
    do_req(1'b0, 1'b0, 24'h000123, 8'h00);
    fork
      do_req(1'b0, 1'b0, 24'h000200, 8'h00);
      do_req(1'b1, 1'b0, 24'h000300, 8'h00);
    join
    fork
      for (int i = 0; i < 8; i++) do_req(1'b0, 1'($urandom_range(0, 1)), 24'($urandom), 8'($urandom));
      begin
        repeat (2) begin @(posedge clk); #1; end
        do_req(1'b1, 1'b0, 24'h000777, 8'h00);
      end
    join
    do_req(1'b1, 1'b1, 24'h000040, 8'hC3);

    mem_dead = 1'b1;
    do_req(1'b0, 1'b0, 24'h000055, 8'h00);
    mem_dead = 1'b0;
    lat_left = 0;

    fork
      rand_stream(1'b0, 40, 2);
      rand_stream(1'b1, 30, 5);
    join
    @(negedge clk);
    chk("tout_err_sticky", 32'(tout_err), 32'd1);

    // Reset in the middle of a B read that the memory never answers.
    @(posedge clk); #1;
    mon_en = 1'b0;
    mem_dead = 1'b1;
    b_we = 1'b0; b_addr = 24'h000099; b_req = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("busy_before_rst", 32'(m_req), 32'd1);
    rst = 1'b1;
    b_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_mem_port", 32'({m_req, m_we, m_addr, m_wdata}), 32'd0);
    chk("rst_busy_outputs", 32'({a_rdata, b_rdata, a_ack, b_ack, owner, tout_err}), 32'd0);
    rst = 1'b0;
    mem_dead = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_ack_after_rst", 32'({b_ack, m_req}), 32'd0);
    end
    exp_a.delete();
    exp_b.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    mon_en = 1'b1;
    do_req(1'b1, 1'b0, 24'h0000AB, 8'h00);

    repeat (4) @(posedge clk);
    chk("queues_drained", 32'(exp_a.size() + exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
